// File: rtl/line_mem_responder.sv
// Line-granular memory responder below the instruction cache controller.
// Serves one whole-line read or write at a time with a fixed latency.
module line_mem_responder #(
    parameter int unsigned LINE_SIZE   = 64,
    parameter int unsigned DEPTH_LINES = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [31:0]            mem_addr,
    input  logic [LINE_SIZE*8-1:0] mem_write_data,
    output logic                   mem_ready,
    output logic                   mem_data_valid,
    output logic [LINE_SIZE*8-1:0] mem_read_data,
    output logic                   mem_err,
    output logic                   proto_err
);

    localparam int unsigned LINE_W = LINE_SIZE * 8;
    localparam int unsigned OFF    = $clog2(LINE_SIZE);
    localparam int unsigned IDX    = $clog2(DEPTH_LINES);
    localparam int unsigned HI     = OFF + IDX;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cap_we_q;
    logic               cap_inwin_q;
    logic [IDX-1:0]     cap_idx_q;
    logic [LINE_W-1:0]  cap_wdata_q;

    logic               ready_d, valid_d, err_d, proto_d;
    logic [LINE_W-1:0]  rdata_d;

    logic [LINE_W-1:0]  mem_q [DEPTH_LINES];

    logic               accept_c, enter_resp_c;
    logic               req_inwin_c;
    logic               we_c, inwin_c;
    logic [IDX-1:0]     idx_c;
    logic [LINE_W-1:0]  wdata_c;
    logic               unused_addr_c;

    assign unused_addr_c = ^mem_addr[OFF-1:0];
    assign req_inwin_c   = (mem_addr[31:HI] == BASE_ADDR[31:HI]);
    assign accept_c      = (state_q == IDLE) && mem_req;

    // Live request fields when accepting, captured fields otherwise (LATENCY=1 commits on the accept edge)
    assign we_c    = accept_c ? mem_we              : cap_we_q;
    assign inwin_c = accept_c ? req_inwin_c         : cap_inwin_q;
    assign idx_c   = accept_c ? mem_addr[HI-1:OFF]  : cap_idx_q;
    assign wdata_c = accept_c ? mem_write_data      : cap_wdata_q;

    // Next state, counter and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        enter_resp_c = (state_d == RESP) && (state_q != RESP);
        ready_d      = (state_d == IDLE);
        valid_d      = (state_d == RESP);
        err_d        = (state_d == RESP) && !inwin_c;
        proto_d      = proto_err | (mem_req && (state_q != IDLE));

        rdata_d = mem_read_data;
        if (enter_resp_c && !we_c) begin
            rdata_d = inwin_c ? mem_q[idx_c] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cap_we_q       <= 1'b0;
            cap_inwin_q    <= 1'b0;
            cap_idx_q      <= '0;
            cap_wdata_q    <= '0;
            mem_ready      <= 1'b1;
            mem_data_valid <= 1'b0;
            mem_err        <= 1'b0;
            proto_err      <= 1'b0;
            mem_read_data  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_ready      <= ready_d;
            mem_data_valid <= valid_d;
            mem_err        <= err_d;
            proto_err      <= proto_d;
            mem_read_data  <= rdata_d;
            if (accept_c) begin
                cap_we_q    <= mem_we;
                cap_inwin_q <= req_inwin_c;
                cap_idx_q   <= mem_addr[HI-1:OFF];
                cap_wdata_q <= mem_write_data;
            end
        end
    end

    // Line array has no reset; contents survive rst_n
    always_ff @(posedge clk) begin
        if (enter_resp_c && we_c && inwin_c) begin
            mem_q[idx_c] <= wdata_c;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench: LATENCY=4 instance (a) and LATENCY=1 instance (b).
module tb_line_mem_responder;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [511:0] wdata;

    logic         a_req, a_ready, a_valid, a_err, a_proto;
    logic [511:0] a_rdata;
    logic         b_req, b_ready, b_valid, b_err, b_proto;
    logic [511:0] b_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] d_a5, d_1, d_2, d_3, d_old, d_new, d_5, d_junk;

    assign a_req = req & ~sel;
    assign b_req = req & sel;

    line_mem_responder #(.LATENCY(4)) u_a (
        .clk(clk), .rst_n(rst_n), .mem_req(a_req), .mem_we(we), .mem_addr(addr),
        .mem_write_data(wdata), .mem_ready(a_ready), .mem_data_valid(a_valid),
        .mem_read_data(a_rdata), .mem_err(a_err), .proto_err(a_proto)
    );

    line_mem_responder #(.LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .mem_req(b_req), .mem_we(we), .mem_addr(addr),
        .mem_write_data(wdata), .mem_ready(b_ready), .mem_data_valid(b_valid),
        .mem_read_data(b_rdata), .mem_err(b_err), .proto_err(b_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a one-cycle request; returns at the negedge of the cycle after acceptance
    task automatic issue(input logic s, input logic w, input logic [31:0] a, input logic [511:0] d);
        sel   = s;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        step();
        req   = 1'b0;
    endtask

    // Full LATENCY=4 transaction on instance a with cycle-exact checks
    task automatic txn4(input string tag, input logic w, input logic [31:0] a, input logic [511:0] d,
                        input logic exp_err, input logic [511:0] exp_rd);
        issue(1'b0, w, a, d);
        check({tag, ".ready_n1"}, a_ready, 0);
        step();
        step();
        check({tag, ".valid_n3"}, a_valid, 0);
        step();
        check({tag, ".valid_n4"}, a_valid, 1);
        check({tag, ".ready_n4"}, a_ready, 0);
        check({tag, ".err"}, a_err, exp_err);
        if (!w) check({tag, ".rdata"}, a_rdata, exp_rd);
        step();
        check({tag, ".valid_n5"}, a_valid, 0);
        check({tag, ".ready_n5"}, a_ready, 1);
    endtask

    initial begin
        d_a5   = {32{16'hA5A5}};
        d_1    = {16{32'h1111_0FFC}};
        d_2    = {16{32'h2222_0000}};
        d_3    = {16{32'hDEAD_BEEF}};
        d_old  = {16{32'h0BAD_0080}};
        d_new  = {16{32'hFEED_0080}};
        d_5    = {16{32'h5555_0100}};
        d_junk = {16{32'h0123_4567}};

        rst_n = 1'b0;
        sel   = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        step();
        step();
        check("rst.a_ready", a_ready, 1);
        check("rst.a_valid", a_valid, 0);
        check("rst.a_err",   a_err,   0);
        check("rst.a_proto", a_proto, 0);
        check("rst.a_rdata", a_rdata, 0);
        check("rst.b_ready", b_ready, 1);
        check("rst.b_rdata", b_rdata, 0);
        rst_n = 1'b1;
        step();

        // Basic write/read, offset bits ignored
        txn4("wr40",   1'b1, 32'h0000_0040, d_a5, 1'b0, '0);
        txn4("rd40",   1'b0, 32'h0000_0040, '0,   1'b0, d_a5);
        txn4("rd7c",   1'b0, 32'h0000_007C, '0,   1'b0, d_a5);

        // Top and bottom index, no aliasing
        txn4("wrffc0", 1'b1, 32'h0000_FFC0, d_1,  1'b0, '0);
        txn4("wr0",    1'b1, 32'h0000_0000, d_2,  1'b0, '0);
        txn4("rdffc0", 1'b0, 32'h0000_FFC0, '0,   1'b0, d_1);
        txn4("rd0",    1'b0, 32'h0000_0000, '0,   1'b0, d_2);

        // Out of window
        txn4("rdoow",  1'b0, 32'h0001_0000, '0,   1'b1, '0);
        txn4("wroow",  1'b1, 32'h0001_0000, d_3,  1'b1, '0);
        txn4("rd0b",   1'b0, 32'h0000_0000, '0,   1'b0, d_2);

        // Request while busy: ignored, sticky proto_err
        issue(1'b0, 1'b0, 32'h0000_0040, '0);
        step();
        sel   = 1'b0;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h0000_0040;
        wdata = d_junk;
        step();
        req   = 1'b0;
        check("busy.proto_n3", a_proto, 1);
        check("busy.valid_n3", a_valid, 0);
        step();
        check("busy.valid_n4", a_valid, 1);
        check("busy.rdata",    a_rdata, d_a5);
        check("busy.err",      a_err,   0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("busy.no_second", a_valid, 0);
        end
        check("busy.proto_sticky", a_proto, 1);
        txn4("rd40b",  1'b0, 32'h0000_0040, '0,   1'b0, d_a5);

        // Reset mid-write: write not committed, outputs back to reset values
        txn4("wr80",   1'b1, 32'h0000_0080, d_old, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h0000_0080, d_new);
        step();
        rst_n = 1'b0;
        #1;
        check("mrst.ready", a_ready, 1);
        check("mrst.valid", a_valid, 0);
        check("mrst.err",   a_err,   0);
        check("mrst.proto", a_proto, 0);
        check("mrst.rdata", a_rdata, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        txn4("rd80",   1'b0, 32'h0000_0080, '0,   1'b0, d_old);

        // LATENCY=1 back-to-back write then read
        issue(1'b1, 1'b1, 32'h0000_0100, d_5);
        check("l1.wr_valid", b_valid, 1);
        check("l1.wr_ready", b_ready, 0);
        check("l1.wr_err",   b_err,   0);
        step();
        check("l1.gap_valid", b_valid, 0);
        check("l1.gap_ready", b_ready, 1);
        issue(1'b1, 1'b0, 32'h0000_0100, '0);
        check("l1.rd_valid", b_valid, 1);
        check("l1.rd_rdata", b_rdata, d_5);
        step();
        check("l1.rd_done",  b_valid, 0);
        check("l1.proto",    b_proto, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
